// File: rtl/uart_pkg.sv
// Shared definitions for the uart_clk-domain receive/transmit blocks.
package uart_pkg;

   localparam int unsigned CLK_PER_BIT_DEFAULT = 87;
   localparam int unsigned DATA_BITS           = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs into the uart_clk domain.
// Resets to 1 so an idle-high serial line does not look like a start bit.
module uart_sync2 (
   input  logic uart_clk,
   input  logic uart_rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge uart_clk or negedge uart_rst_n) begin
      if (!uart_rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receive engine: mid-bit sampling FSM feeding a one-entry
// valid/ready holding register, with framing, overrun and break reporting.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
   input  logic                 uart_clk,
   input  logic                 uart_rst_n,
   input  logic                 uart_rx_pin,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 break_det,
   output logic                 rx_busy
);

   localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] HALF_C = CNT_W'((CLK_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CLK_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 line;
   uart_state_t          state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
   logic [DATA_BITS-1:0] shift, shift_nxt;
   logic                 deliver;
   logic                 ferr;
   logic                 brk_set;
   logic                 brk_clr;

   uart_sync2 u_sync (
      .uart_clk   (uart_clk),
      .uart_rst_n (uart_rst_n),
      .d          (uart_rx_pin),
      .q          (line)
   );

   always_ff @(posedge uart_clk or negedge uart_rst_n) begin
      if (!uart_rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_idx_nxt;
         shift   <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      deliver     = 1'b0;
      ferr        = 1'b0;
      brk_set     = 1'b0;
      brk_clr     = 1'b0;

      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!line) begin
               state_nxt = START;
            end
         end

         START: begin
            if (cnt == HALF_C) begin
               cnt_nxt     = '0;
               bit_idx_nxt = '0;
               state_nxt   = line ? IDLE : DATA;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         DATA: begin
            if (cnt == LAST_C) begin
               cnt_nxt   = '0;
               shift_nxt = {line, shift[DATA_BITS-1:1]};
               if (bit_idx == IDX_LAST) begin
                  state_nxt = STOP;
               end else begin
                  bit_idx_nxt = bit_idx + IDX_W'(1);
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         STOP: begin
            if (cnt == LAST_C) begin
               cnt_nxt = '0;
               // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
               if (line) begin
                  deliver   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr      = 1'b1;
                  brk_set   = (shift == '0);
                  state_nxt = WAIT_HIGH;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         WAIT_HIGH: begin
            cnt_nxt = '0;
            if (line) begin
               brk_clr   = 1'b1;
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge uart_clk or negedge uart_rst_n) begin
      if (!uart_rst_n) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
         break_det   <= 1'b0;
      end else begin
         frame_err   <= ferr;
         overrun_err <= deliver & rx_valid & ~rx_ready;

         if (deliver) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift;
               rx_valid <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         if (brk_set) begin
            break_det <= 1'b1;
         end else if (brk_clr) begin
            break_det <= 1'b0;
         end
      end
   end

   assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler at the default 87 cycles per bit.
module tb_uart_rx_sampler;

   localparam int CPB = 87;

   logic       uart_clk = 1'b0;
   logic       uart_rst_n;
   logic       uart_rx_pin;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun_err;
   logic       break_det;
   logic       rx_busy;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int n_valid = 0;
   logic [7:0] last_data = '0;
   int rise_cyc = 0;
   int ferr_rise = 0, ferr_hi = 0;
   int ovr_rise = 0, ovr_hi = 0;
   int brk_rise = 0, brk_fall_cyc = 0;
   logic prev_valid = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0, prev_brk = 1'b0;

   uart_rx_sampler #(.CLK_PER_BIT(CPB)) dut (
      .uart_clk    (uart_clk),
      .uart_rst_n  (uart_rst_n),
      .uart_rx_pin (uart_rx_pin),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
      .break_det   (break_det),
      .rx_busy     (rx_busy)
   );

   always #5 uart_clk = ~uart_clk;

   always @(posedge uart_clk) cyc <= cyc + 1;

   always @(negedge uart_clk) begin
      if (rx_valid && !prev_valid) begin
         n_valid   = n_valid + 1;
         last_data = rx_data;
         rise_cyc  = cyc;
      end
      if (frame_err) ferr_hi = ferr_hi + 1;
      if (frame_err && !prev_ferr) ferr_rise = ferr_rise + 1;
      if (overrun_err) ovr_hi = ovr_hi + 1;
      if (overrun_err && !prev_ovr) ovr_rise = ovr_rise + 1;
      if (break_det && !prev_brk) brk_rise = brk_rise + 1;
      if (!break_det && prev_brk) brk_fall_cyc = cyc;
      prev_valid = rx_valid;
      prev_ferr  = frame_err;
      prev_ovr   = overrun_err;
      prev_brk   = break_det;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge uart_clk);
      #1;
   endtask

   task automatic drive_bit(input logic v, input int n);
      uart_rx_pin = v;
      wait_cycles(n);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, input int bitlen);
      drive_bit(1'b0, bitlen);
      for (int i = 0; i < 8; i++) drive_bit(b[i], bitlen);
      drive_bit(stop, bitlen);
      uart_rx_pin = 1'b1;
   endtask

   int t0, lat, nv, fr, orise, brise, r;

   initial begin
      uart_rst_n  = 1'b0;
      uart_rx_pin = 1'b1;
      rx_ready    = 1'b1;
      wait_cycles(3);
      check("rst_data", 32'(rx_data), 32'h00);
      check("rst_flags", {27'd0, rx_valid, frame_err, overrun_err, break_det, rx_busy}, 32'd0);
      uart_rst_n = 1'b1;
      wait_cycles(5);

      // frame 0x55, latency and clean flags
      t0 = cyc;
      send_byte(8'h55, 1'b1, CPB);
      lat = rise_cyc - t0;
      check("b55_count", 32'(n_valid), 32'd1);
      check("b55_data", 32'(last_data), 32'h55);
      check("b55_lat_in_830pm1", 32'(lat >= 829 && lat <= 831), 32'd1);
      check("b55_valid_dropped", 32'(rx_valid), 32'd0);
      check("b55_no_flags", 32'(ferr_rise + ovr_rise + brk_rise), 32'd0);
      wait_cycles(20);

      // 20-cycle glitch, then 0xA3
      drive_bit(1'b0, 20);
      uart_rx_pin = 1'b1;
      wait_cycles(100);
      check("glitch_nothing", 32'(n_valid), 32'd1);
      check("glitch_idle", 32'(rx_busy), 32'd0);
      send_byte(8'hA3, 1'b1, CPB);
      check("bA3_count", 32'(n_valid), 32'd2);
      check("bA3_data", 32'(last_data), 32'hA3);
      wait_cycles(20);

      // 0xA5 with low stop bit
      nv = n_valid;
      send_byte(8'hA5, 1'b0, CPB);
      wait_cycles(50);
      check("bA5_ferr", 32'(ferr_rise), 32'd1);
      check("bA5_no_valid", 32'(n_valid), 32'(nv));
      check("bA5_no_break", 32'(brk_rise), 32'd0);
      check("bA5_data_kept", 32'(rx_data), 32'hA3);

      // break: 11 bit-times low
      drive_bit(1'b0, 11 * CPB);
      check("brk_ferr", 32'(ferr_rise), 32'd2);
      check("brk_high", 32'(break_det), 32'd1);
      check("brk_busy", 32'(rx_busy), 32'd1);
      r = cyc;
      uart_rx_pin = 1'b1;
      wait_cycles(10);
      check("brk_fall_delay", 32'(brk_fall_cyc - r), 32'd3);
      check("brk_low", 32'(break_det), 32'd0);
      send_byte(8'h3C, 1'b1, CPB);
      check("b3C_data", 32'(last_data), 32'h3C);
      check("b3C_count", 32'(n_valid), 32'(nv + 1));
      wait_cycles(20);

      // rate tolerance: about -2.3% and +2.3%
      send_byte(8'hC6, 1'b1, 85);
      check("fast_data", 32'(last_data), 32'hC6);
      wait_cycles(20);
      send_byte(8'h9B, 1'b1, 89);
      check("slow_data", 32'(last_data), 32'h9B);
      check("rate_no_ferr", 32'(ferr_rise), 32'd2);
      wait_cycles(20);

      // back-to-back 0x12, 0x34 with consumer stalled
      rx_ready = 1'b0;
      orise = ovr_rise;
      send_byte(8'h12, 1'b1, CPB);
      send_byte(8'h34, 1'b1, CPB);
      wait_cycles(100);
      check("ovr_valid", 32'(rx_valid), 32'd1);
      check("ovr_data_held", 32'(rx_data), 32'h12);
      check("ovr_pulse", 32'(ovr_rise - orise), 32'd1);
      rx_ready = 1'b1;
      wait_cycles(1);
      rx_ready = 1'b0;
      check("ovr_drained", 32'(rx_valid), 32'd0);
      check("ovr_data_stays", 32'(rx_data), 32'h12);
      rx_ready = 1'b1;
      wait_cycles(20);

      // reset mid-frame of 0xF0
      fr = ferr_rise;
      brise = brk_rise;
      drive_bit(1'b0, CPB);
      drive_bit(1'b0, CPB);
      drive_bit(1'b0, CPB / 2);
      check("mid_busy", 32'(rx_busy), 32'd1);
      uart_rst_n = 1'b0;
      #2;
      check("arst_data", 32'(rx_data), 32'h00);
      check("arst_flags", {27'd0, rx_valid, frame_err, overrun_err, break_det, rx_busy}, 32'd0);
      uart_rx_pin = 1'b1;
      wait_cycles(5);
      uart_rst_n = 1'b1;
      wait_cycles(5);
      send_byte(8'h0F, 1'b1, CPB);
      wait_cycles(10);
      check("b0F_data", 32'(last_data), 32'h0F);
      check("b0F_no_flags", 32'((ferr_rise - fr) + (brk_rise - brise)), 32'd0);
      check("pulse_width_ferr", 32'(ferr_hi), 32'(ferr_rise));
      check("pulse_width_ovr", 32'(ovr_hi), 32'(ovr_rise));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
